// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs; both flops clear on reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one mechanical button: synchronise, require a stable run of samples,
// then emit registered press/release pulses, a clean level and optional auto-repeat.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int INVERT          = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] R_FIRST  = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] R_NEXT   = RCNT_W'(REPEAT_PERIOD);
  localparam logic              INV_BIT  = (INVERT != 0);

  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    PRESS_CHK   = 2'b01,
    HELD        = 2'b10,
    RELEASE_CHK = 2'b11
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RCNT_W-1:0] rcnt_inc(input logic [RCNT_W-1:0] v);
    return (v == {RCNT_W{1'b1}}) ? v : v + RCNT_W'(1);
  endfunction

  logic p, s;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d, rinc, rtarget;
  logic               rarm_q, rarm_d;
  logic               level_d, press_d, release_d, repeat_d, held;

  assign p = btn_raw ^ INV_BIT;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (p),
    .q     (s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rcnt_d    = rcnt_q;
    rarm_d    = rarm_q;
    repeat_d  = 1'b0;
    rinc      = rcnt_inc(rcnt_q);
    rtarget   = rarm_q ? R_NEXT : R_FIRST;
    held      = (state_q == HELD) || (state_q == RELEASE_CHK);

    case (state_q)
      RELEASED: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      HELD: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = RELEASED;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Repeat timer: restarts on press, rearms for the period after each pulse,
    // and is silenced on the release cycle so pulses never overlap events.
    if (press_d) begin
      rcnt_d = '0;
      rarm_d = 1'b0;
    end else if ((REPEAT_DELAY > 0) && held && !release_d) begin
      if (rinc == rtarget) begin
        repeat_d = 1'b1;
        rcnt_d   = '0;
        rarm_d   = 1'b1;
      end else begin
        rcnt_d = rinc;
      end
    end

    level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rarm_q      <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      rarm_q      <= rarm_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected pulse events with their cycle numbers;
// per-instance monitors pop and compare whenever a pulse output is seen.
module tb_button_debouncer;

  typedef struct {
    int cyc;
    int kind;   // 0 press, 1 release, 2 repeat
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic raw_a, raw_b;
  logic level_a, press_a, release_a, repeat_a;
  logic level_b, press_b, release_b, repeat_b;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .INVERT          (0)
  ) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (raw_a),
    .btn_level   (level_a),
    .btn_press   (press_a),
    .btn_release (release_a),
    .btn_repeat  (repeat_a)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (0),
    .REPEAT_PERIOD   (8),
    .INVERT          (1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (raw_b),
    .btn_level   (level_b),
    .btn_press   (press_b),
    .btn_release (release_b),
    .btn_repeat  (repeat_b)
  );

  function automatic string kname(input int k);
    case (k)
      0:       return "press";
      1:       return "release";
      default: return "repeat";
    endcase
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    logic [2:0] pa;
    ev_t ev;
    pa = {repeat_a, release_a, press_a};
    for (int k = 0; k < 3; k++) begin
      if (pa[k]) begin
        checks++;
        if (qa.size() == 0) begin
          $display("FAIL dut_a_event: unexpected %s at cycle %0d, expected none", kname(k), cyc);
        end else begin
          ev = qa.pop_front();
          if (ev.kind == k && ev.cyc == cyc) passes++;
          else $display("FAIL dut_a_event: got %s at cycle %0d, expected %s at cycle %0d",
                        kname(k), cyc, kname(ev.kind), ev.cyc);
        end
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    logic [2:0] pb;
    ev_t ev;
    pb = {repeat_b, release_b, press_b};
    for (int k = 0; k < 3; k++) begin
      if (pb[k]) begin
        checks++;
        if (qb.size() == 0) begin
          $display("FAIL dut_b_event: unexpected %s at cycle %0d, expected none", kname(k), cyc);
        end else begin
          ev = qb.pop_front();
          if (ev.kind == k && ev.cyc == cyc) passes++;
          else $display("FAIL dut_b_event: got %s at cycle %0d, expected %s at cycle %0d",
                        kname(k), cyc, kname(ev.kind), ev.cyc);
        end
      end
    end
  end

  // Press at current negedge, hold for 'hold' cycles, then release.
  // Press lands 6 cycles after the drive (1 to the first sample edge + 1 + DEBOUNCE_CYCLES).
  task automatic press_hold_a(input int hold);
    int c, p, r;
    c = cyc;
    p = c + 6;
    r = c + hold + 6;
    qa.push_back('{p, 0});
    for (int t = p + 10; t < r; t += 3) qa.push_back('{t, 2});
    qa.push_back('{r, 1});
    raw_a = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_press_level_a", level_a, 1'b0);
    @(negedge clk);
    chk("press_level_a", level_a, 1'b1);
    repeat (hold - 6) @(negedge clk);
    chk("held_level_a", level_a, 1'b1);
    raw_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("released_level_a", level_a, 1'b0);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_level_a",   level_a,   1'b0);
    chk("rst_press_a",   press_a,   1'b0);
    chk("rst_release_a", release_a, 1'b0);
    chk("rst_repeat_a",  repeat_a,  1'b0);
    chk("rst_level_b",   level_b,   1'b0);
    chk("rst_press_b",   press_b,   1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Clean press with a long hold: auto-repeat 10 after press, then every 3
    press_hold_a(40);

    // Bounce: single-cycle alternation never satisfies the stable count
    for (int i = 0; i < 12; i++) begin
      raw_a = (i % 2 == 0);
      @(negedge clk);
    end
    chk("bounce_level_a", level_a, 1'b0);
    press_hold_a(20);

    // Release glitch of 2 cycles is absorbed; a 10-cycle drop releases
    c = cyc;
    qa.push_back('{c + 6, 0});
    for (int t = c + 16; t < c + 28; t += 3) qa.push_back('{t, 2});
    qa.push_back('{c + 28, 1});
    raw_a = 1'b1;
    repeat (12) @(negedge clk);
    raw_a = 1'b0;
    repeat (2) @(negedge clk);
    raw_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("glitch_level_a", level_a, 1'b1);
    end
    raw_a = 1'b0;
    repeat (10) @(negedge clk);
    repeat (15) @(negedge clk);
    chk("glitch_released_level_a", level_a, 1'b0);

    // Reset during PRESS_CHK, button still held afterwards
    c = cyc;
    raw_a = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_level_a", level_a, 1'b0);
    chk("midrst_press_a", press_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    qa.push_back('{c + 11, 0});
    qa.push_back('{c + 21, 2});
    qa.push_back('{c + 24, 2});
    qa.push_back('{c + 26, 1});
    repeat (5) @(negedge clk);
    chk("postrst_pre_level_a", level_a, 1'b0);
    @(negedge clk);
    chk("postrst_press_level_a", level_a, 1'b1);
    repeat (9) @(negedge clk);
    raw_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("postrst_released_level_a", level_a, 1'b0);

    // Active-low input: idle high reads as released, driving low presses
    c = cyc;
    chk("inv_idle_level_b", level_b, 1'b0);
    qb.push_back('{c + 6, 0});
    qb.push_back('{c + 26, 1});
    raw_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("inv_pre_level_b", level_b, 1'b0);
    @(negedge clk);
    chk("inv_press_level_b", level_b, 1'b1);
    repeat (14) @(negedge clk);
    raw_b = 1'b1;
    repeat (15) @(negedge clk);
    chk("inv_released_level_b", level_b, 1'b0);

    repeat (5) @(negedge clk);
    chk_int("dut_a_pending_events", qa.size(), 0);
    chk_int("dut_b_pending_events", qb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
